// File: rtl/stack_unit_if.sv
// Push/pop command and stack status bundle between the controller datapath and the operand stack.
interface stack_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PTR_W = 4
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             ack;
    logic             err_ovf;
    logic             err_udf;

    modport master (
        output push, pop, din, clr_err,
        input  tos, nos, count, empty, full, ack, err_ovf, err_udf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output tos, nos, count, empty, full, ack, err_ovf, err_udf
    );
endinterface

// File: rtl/stack_unit.sv
// Hardware operand stack: one push/pop/replace per clock with registered top/next-on-stack,
// occupancy and sticky overflow/underflow flags.
module stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             is_empty, is_full;
    logic             do_push, do_pop, do_repl;
    logic             mem_we;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] idx_m1, idx_m2, idx_m3;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Push+pop on an empty stack degrades to a plain push; on a non-empty stack it replaces the top.
    assign do_repl = bus.push & bus.pop & ~is_empty;
    assign do_push = bus.push & ((~bus.pop & ~is_full) | (bus.pop & is_empty));
    assign do_pop  = bus.pop & ~bus.push & ~is_empty;

    assign idx_m1 = count_q - CNT_W'(1);
    assign idx_m2 = count_q - CNT_W'(2);
    assign idx_m3 = count_q - CNT_W'(3);

    // Next-state: operands below the valid depth read as zero, so stale storage never leaks out.
    always_comb begin
        count_d = count_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        ack_d   = 1'b0;
        mem_we  = 1'b0;
        wr_idx  = PTR_W'(count_q);
        if (do_push) begin
            mem_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
            tos_d   = bus.din;
            nos_d   = tos_q;
            ack_d   = 1'b1;
        end else if (do_repl) begin
            mem_we  = 1'b1;
            wr_idx  = PTR_W'(idx_m1);
            tos_d   = bus.din;
            ack_d   = 1'b1;
        end else if (do_pop) begin
            count_d = idx_m1;
            tos_d   = (count_q >= CNT_W'(2)) ? mem[PTR_W'(idx_m2)] : '0;
            nos_d   = (count_q >= CNT_W'(3)) ? mem[PTR_W'(idx_m3)] : '0;
            ack_d   = 1'b1;
        end
        ovf_d = (ovf_q & ~bus.clr_err) | (bus.push & ~bus.pop & is_full);
        udf_d = (udf_q & ~bus.clr_err) | (bus.pop & ~bus.push & is_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left unreset; the read guards above make its contents irrelevant.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= bus.din;
        end
    end

    assign bus.tos     = tos_q;
    assign bus.nos     = nos_q;
    assign bus.count   = count_q;
    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.ack     = ack_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: queue-based reference stack, directed scenarios plus random traffic.
module tb_stack_unit;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;

    typedef struct {
        logic [WIDTH-1:0] tos;
        logic [WIDTH-1:0] nos;
        logic [PTR_W:0]   count;
        logic             empty;
        logic             full;
        logic             ack;
        logic             ovf;
        logic             udf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stack_unit_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t             exp_q [$];
    logic [WIDTH-1:0] stk [$];
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a plain queue plus two flags, updated from the operation rules.
    function automatic void model_step(bit p, bit q, logic [WIDTH-1:0] d, bit c);
        exp_t e;
        bit   acc = 1'b0;
        bit   ovf_evt = 1'b0;
        bit   udf_evt = 1'b0;
        int   n = stk.size();
        if (p && q && n > 0) begin
            stk[n-1] = d;
            acc = 1'b1;
        end else if (p) begin
            if (n < DEPTH) begin
                stk.push_back(d);
                acc = 1'b1;
            end else begin
                ovf_evt = 1'b1;
            end
        end else if (q) begin
            if (n > 0) begin
                void'(stk.pop_back());
                acc = 1'b1;
            end else begin
                udf_evt = 1'b1;
            end
        end
        m_ovf = (m_ovf && !c) || ovf_evt;
        m_udf = (m_udf && !c) || udf_evt;
        n = stk.size();
        e.tos   = (n > 0) ? stk[n-1] : '0;
        e.nos   = (n > 1) ? stk[n-2] : '0;
        e.count = (PTR_W+1)'(n);
        e.empty = (n == 0);
        e.full  = (n == DEPTH);
        e.ack   = acc;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);
    endfunction

    task automatic op(input bit p, input bit q, input logic [WIDTH-1:0] d, input bit c);
        @(negedge clk);
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.clr_err = c;
        @(posedge clk);
        model_step(p, q, d, c);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && stk.size() > 0; k++) op(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_tos"},   32'(bus.tos),     32'h0);
        check({tag, "_nos"},   32'(bus.nos),     32'h0);
        check({tag, "_count"}, 32'(bus.count),   32'h0);
        check({tag, "_empty"}, 32'(bus.empty),   32'h1);
        check({tag, "_ack"},   32'(bus.ack),     32'h0);
        check({tag, "_ovf"},   32'(bus.err_ovf), 32'h0);
        check({tag, "_udf"},   32'(bus.err_udf), 32'h0);
    endtask

    // Monitor: every edge that had a request queued produces one expected response.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("tos",     32'(bus.tos),     32'(e.tos));
            check("nos",     32'(bus.nos),     32'(e.nos));
            check("count",   32'(bus.count),   32'(e.count));
            check("empty",   32'(bus.empty),   32'(e.empty));
            check("full",    32'(bus.full),    32'(e.full));
            check("ack",     32'(bus.ack),     32'(e.ack));
            check("err_ovf", 32'(bus.err_ovf), 32'(e.ovf));
            check("err_udf", 32'(bus.err_udf), 32'(e.udf));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.din = '0;
        bus.clr_err = 1'b0;
        #2;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b1;

        op(1'b1, 1'b0, 8'h11, 1'b0);
        op(1'b1, 1'b0, 8'h22, 1'b0);
        op(1'b1, 1'b0, 8'h33, 1'b0);
        #1;
        check("plan_tos33", 32'(bus.tos), 32'h33);
        check("plan_nos22", 32'(bus.nos), 32'h22);
        op(1'b0, 1'b1, '0, 1'b0);
        op(1'b0, 1'b1, '0, 1'b0);
        op(1'b0, 1'b1, '0, 1'b0);
        op(1'b0, 1'b1, '0, 1'b0);
        op(1'b0, 1'b1, '0, 1'b1);
        op(1'b0, 1'b0, '0, 1'b1);
        #1;
        check("plan_udf_cleared", 32'(bus.err_udf), 32'h0);

        for (int v = 1; v <= DEPTH; v++) op(1'b1, 1'b0, 8'(v), 1'b0);
        op(1'b1, 1'b0, 8'hAA, 1'b0);
        #1;
        check("plan_full_tos", 32'(bus.tos), 32'd16);
        check("plan_ovf", 32'(bus.err_ovf), 32'h1);
        op(1'b1, 1'b1, 8'hBB, 1'b0);
        drain();
        op(1'b1, 1'b0, 8'h04, 1'b1);
        op(1'b1, 1'b0, 8'h05, 1'b0);
        op(1'b1, 1'b1, 8'h09, 1'b0);
        #1;
        check("plan_repl_nos", 32'(bus.nos), 32'h04);
        drain();
        op(1'b1, 1'b1, 8'h07, 1'b0);
        op(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            int unsigned pp;
            bit p;
            bit q;
            bit c;
            pp = ((i / 150) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < pp);
            q = ($urandom_range(0, 99) < (100 - pp));
            c = ($urandom_range(0, 15) == 0);
            op(p, q, 8'($urandom), c);
        end

        op(1'b1, 1'b0, 8'h61, 1'b0);
        op(1'b1, 1'b0, 8'h62, 1'b0);
        op(1'b1, 1'b0, 8'h63, 1'b0);
        #3;
        rst = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.clr_err = 1'b0;
        #1;
        check_cleared("midreset");
        stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        op(1'b1, 1'b0, 8'h5A, 1'b0);
        #1;
        check("post_reset_tos", 32'(bus.tos), 32'h5A);
        check("post_reset_count", 32'(bus.count), 32'h1);
        op(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack. It is the responder for the controller's push/pop requests in the stack-machine processor.
- It takes push/pop commands and write data from the datapath.
- It presents registered top-of-stack (tos) and next-on-stack (nos) values to the datapath's A/B operand registers.
- It reports occupancy, full/empty and sticky overflow/underflow errors. One operation per clock, single-cycle response.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries. Must be a power of two, at least 4.
- PTR_W, 4, log2(DEPTH). The integrator sets it consistently with DEPTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 immediately clears state; release is synchronous to clk by the integrator.
- push  input  1  push request, sampled at rising clk.
- pop  input  1  pop request, sampled at rising clk.
- din  input  WIDTH  data to push.
- clr_err  input  1  clears the sticky error flags.
- tos  output  WIDTH  registered top-of-stack value; 0 when empty.
- nos  output  WIDTH  registered second entry; 0 when count<2.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0 (combinational from count).
- full  output  1  count==DEPTH (combinational from count).
- ack  output  1  one-cycle pulse: the operation sampled at the previous edge was accepted.
- err_ovf  output  1  sticky: a push was attempted while full.
- err_udf  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous): count=0, tos=0, nos=0, ack=0, err_ovf=0, err_udf=0.
  - Storage array contents are not cleared and are don't-care. Read paths must never expose them: tos/nos are forced to 0 below their valid depth.
- Storage: DEPTH x WIDTH register array. Entry i is valid for i<count. The top is at index count-1.
- Latency: a request sampled at edge N updates tos/nos/count/ack/flags at edge N. New values are visible in cycle N+1. ack is high for exactly cycle N+1, with no back-to-back merging beyond one pulse per accepted op.
- Push only (push=1, pop=0, !full):
  - mem[count]<=din; count<=count+1; tos<=din; nos<=old tos; ack<=1.
- Pop only (pop=1, push=0, !empty):
  - count<=count-1.
  - tos<=mem[count-2] if count>=2, else 0.
  - nos<=mem[count-3] if count>=3, else 0.
  - ack<=1.
- Push and pop together (replace top):
  - If !empty: mem[count-1]<=din; tos<=din; nos and count unchanged; ack<=1. This applies even when full; no overflow is raised.
  - If empty: behaves as push only. No underflow is raised.
- Push while full (pop=0): request ignored; storage, count, tos and nos unchanged; err_ovf<=1; ack<=0.
- Pop while empty (push=0): request ignored; err_udf<=1; ack<=0.
- Idle (push=0, pop=0): all state held; ack<=0.
- clr_err=1 clears both flags at the edge. If a new error occurs in the same cycle, the set wins for that flag.
- Wrap-around: none. count saturates at DEPTH/0 via the full/empty rejection above. The pointer never wraps.
- Reset asserted mid-sequence: state clears immediately regardless of clk. After release, the first accepted push lands in entry 0.
- Index arithmetic uses PTR_W+1 bits. Underflowed indices (count-2, count-3 below 0) must never address the array; they are guarded by the count comparisons above.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> each cycle after: ack=1; finally count=3, tos=0x33, nos=0x22.
- From that state, pop twice -> tos=0x22/nos=0x11, then tos=0x11/nos=0; count=1. A third pop gives empty=1, tos=0, nos=0, err_udf=0.
- Pop on empty -> ack=0, err_udf=1, count=0. Then clr_err together with another empty pop -> err_udf stays 1. clr_err alone -> err_udf=0.
- Fill with DEPTH pushes (values 1..16) -> full=1, tos=16, nos=15. Push 0xAA -> err_ovf=1, ack=0, tos=16. Push+pop with din=0xBB -> tos=0xBB, count=16, ack=1, no new error.
- With count=2 (tos=0x05, nos=0x04), push+pop din=0x09 -> tos=0x09, nos=0x04, count=2. On empty, push+pop din=0x07 -> count=1, tos=0x07, err_udf=0.
- Push 3 values, assert rst=0 mid-cycle (between edges) -> outputs 0 immediately. After release, push 0x5A -> count=1, tos=0x5A, nos=0.
